// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants for the fetch-stage program-counter slice.
// It holds the control-level encodings used across the fetch logic and the
// state encodings of the pc generator. These are plain localparams so that
// older code comparing against raw bit values stays compatible.
package pc_gen_pkg;

  // Control-level encodings
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic NO_STOP      = 1'b0;
  localparam logic BRANCH       = 1'b1;

  // pc generator states: start-up (ce low) and run (ce high)
  localparam logic [0:0] ST_START = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle between the pc generator and its environment.
//   stall                   pipeline stall vector (bit 0 freezes pc)
//   imem_ready_i            instruction memory accepts the current pc
//   branch_flag_i/_target   branch redirect from ID
//   flush_i/flush_target_i  exception/flush redirect (highest priority)
//   pc, ce                  registered fetch address and chip enable
//   redirect_pending_o      a buffered branch target is waiting
//   misalign_o              one-cycle pulse after a misaligned target load
// Modport master is the pc generator; slave is the surrounding pipeline.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  import pc_gen_pkg::*;

  logic [STALL_W-1:0] stall;
  logic               imem_ready_i;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic               flush_i;
  logic [ADDR_W-1:0]  flush_target_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redirect_pending_o;
  logic               misalign_o;

  modport master (
    input  stall, imem_ready_i, branch_flag_i, branch_target_address_i,
           flush_i, flush_target_i,
    output pc, ce, redirect_pending_o, misalign_o
  );

  modport slave (
    output stall, imem_ready_i, branch_flag_i, branch_target_address_i,
           flush_i, flush_target_i,
    input  pc, ce, redirect_pending_o, misalign_o
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry holder for a branch target that arrived while
// fetch could not advance.
//   clk, rst     clock and synchronous active-high reset
//   capture      store load_target and mark the entry valid (overwrites)
//   clear        drop the entry; wins over capture
//   load_target  target to store
//   valid        registered: an entry is held
//   target       registered: the held target (raw, not yet aligned)
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_target,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  logic              valid_r;
  logic [ADDR_W-1:0] target_r;

  // Entry state: clear dominates, capture overwrites any older target
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid_r  <= 1'b0;
      target_r <= '0;
    end else if (clear) begin
      valid_r  <= 1'b0;
      target_r <= target_r;
    end else if (capture) begin
      valid_r  <= 1'b1;
      target_r <= load_target;
    end else begin
      valid_r  <= valid_r;
      target_r <= target_r;
    end
  end

  assign valid  = valid_r;
  assign target = target_r;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised program-counter generator for the fetch stage.
//   clk, rst  clock and synchronous active-high reset
//   bus       pc_gen_if master: stall/ready, branch and flush redirects in;
//             registered pc, ce, redirect_pending_o and misalign_o out
// After reset ce rises one edge later with pc at RESET_VECTOR. In run state
// the next pc is chosen by flush > live branch > buffered branch > sequential
// step > hold. A branch seen while fetch cannot advance is parked in
// pc_redirect_buf and applied on the next advancing edge.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              STALL_W      = 6,
  parameter int              ALIGN_BITS   = 2
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  // Low target bits that must be zero; all-zero mask disables the check
  localparam logic [ADDR_W-1:0] LOW_MASK =
    (ADDR_W)'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [0:0]        state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              ce_r;
  logic              misalign_r;

  logic              run_s;
  logic              adv_s;
  logic              branch_s;
  logic              apply_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              target_mis_s;
  logic              buf_capture_s;
  logic              buf_clear_s;
  logic              buf_valid_s;
  logic [ADDR_W-1:0] buf_target_s;
  logic              unused_stall_s;

  // Only stall[0] matters here; the remaining bits belong to later stages
  assign unused_stall_s = ^bus.stall;

  assign run_s    = (state_r == ST_RUN);
  assign adv_s    = (bus.stall[0] == NO_STOP) & bus.imem_ready_i;
  assign branch_s = (bus.branch_flag_i == BRANCH);

  // Park a branch only when it cannot be applied now and no flush overrides
  // it. Any flush, or any advancing edge, consumes or supersedes the entry.
  assign buf_capture_s = run_s & ~adv_s & branch_s & ~bus.flush_i;
  assign buf_clear_s   = run_s & (bus.flush_i | (adv_s & (branch_s | buf_valid_s)));

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .capture     (buf_capture_s),
    .clear       (buf_clear_s),
    .load_target (bus.branch_target_address_i),
    .valid       (buf_valid_s),
    .target      (buf_target_s)
  );

  // Redirect target selection in priority order
  always_comb begin
    apply_s  = 1'b0;
    target_s = '0;
    if (bus.flush_i) begin
      apply_s  = 1'b1;
      target_s = bus.flush_target_i;
    end else if (adv_s & branch_s) begin
      apply_s  = 1'b1;
      target_s = bus.branch_target_address_i;
    end else if (adv_s & buf_valid_s) begin
      apply_s  = 1'b1;
      target_s = buf_target_s;
    end else begin
      apply_s  = 1'b0;
      target_s = '0;
    end
  end

  // Misalignment is judged on the target actually being applied
  assign target_mis_s = |(target_s & LOW_MASK);

  // Next pc: aligned redirect, sequential step (wraps naturally) or hold
  always_comb begin
    next_pc_s = pc_r;
    if (apply_s) begin
      next_pc_s = target_s & ~LOW_MASK;
    end else if (adv_s) begin
      next_pc_s = pc_r + (ADDR_W)'(STEP);
    end else begin
      next_pc_s = pc_r;
    end
  end

  // State, pc, ce and misalign pulse registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r    <= ST_START;
      pc_r       <= RESET_VECTOR;
      ce_r       <= CHIP_DISABLE;
      misalign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_START: begin
          // Redirects are ignored until the first fetch is enabled
          state_r    <= ST_RUN;
          pc_r       <= pc_r;
          ce_r       <= CHIP_ENABLE;
          misalign_r <= 1'b0;
        end
        ST_RUN: begin
          state_r    <= ST_RUN;
          pc_r       <= next_pc_s;
          ce_r       <= CHIP_ENABLE;
          misalign_r <= apply_s & target_mis_s;
        end
        default: begin
          state_r    <= ST_START;
          pc_r       <= RESET_VECTOR;
          ce_r       <= CHIP_DISABLE;
          misalign_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc                 = pc_r;
  assign bus.ce                 = ce_r;
  assign bus.redirect_pending_o = buf_valid_s;
  assign bus.misalign_o         = misalign_r;

endmodule
